// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed seven-segment scanner.
// Walks NUM_DIGITS slots of REFRESH_DIV cycles each. Every slot opens with
// BLANK_CYCLES of all-anodes-off so the previous digit cannot ghost into the
// next one. Segment patterns and the digit mask are snapshotted once per
// frame, so a display update never tears mid-frame.
// Anodes and segments are active-low.
// Optional feature macro: SEVEN_SEG_BRIGHTNESS_EN adds a 4-bit brightness
// input that PWM-gates the drive phase with a free-running 4-bit counter.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [7*NUM_DIGITS-1:0]       seg_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
`ifdef SEVEN_SEG_BRIGHTNESS_EN
  input  logic [3:0]                    brightness,
`endif
  output logic [NUM_DIGITS-1:0]         anodos,
  output logic [6:0]                    seg,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);

  // S_IDLE doubles as the "start pending" flag: the first enabled cycle out
  // of S_IDLE takes a fresh snapshot and begins slot 0.
  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t state, state_nxt;

  logic [DIV_W-1:0]             div_cnt;
  logic [NUM_DIGITS-1:0][6:0]   frame_seg;
  logic [NUM_DIGITS-1:0]        frame_en;
  logic                         start;
  logic                         running;
  logic                         slot_end;
  logic                         frame_end;
  logic                         pwm_on;
  logic                         drive;
  logic [NUM_DIGITS-1:0]        anodos_nxt;
  logic [6:0]                   seg_nxt;

`ifdef SEVEN_SEG_BRIGHTNESS_EN
  logic [3:0] pwm_cnt;

  // Free-running PWM phase; held at 0 while idle so each run starts aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                pwm_cnt <= '0;
    else if (!enable || start) pwm_cnt <= '0;
    else                       pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign pwm_on = (pwm_cnt < brightness);
`else
  assign pwm_on = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the slot/frame boundary strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else if (state == S_IDLE) begin
      state_nxt = S_RUN;
      start     = 1'b1;
    end
    running   = enable && (state == S_RUN);
    slot_end  = running && (div_cnt == DIV_LAST);
    frame_end = slot_end && (digit_idx == IDX_LAST);
  end

  // Refresh divider, slot index and the frame-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= start || frame_end;
      if (!enable || start) begin
        div_cnt   <= '0;
        digit_idx <= '0;
      end else if (slot_end) begin
        div_cnt   <= '0;
        digit_idx <= frame_end ? '0 : digit_idx + 1'b1;
      end else begin
        div_cnt   <= div_cnt + 1'b1;
      end
    end
  end

  // Frame snapshot: only taken at start or at the last slot's wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_seg <= '1;
      frame_en  <= '0;
    end else if (start || frame_end) begin
      frame_seg <= seg_in;
      frame_en  <= digit_en;
    end
  end

  // Drive-phase decode from the registered counters (outputs lag by one).
  always_comb begin
    anodos_nxt = '1;
    seg_nxt    = 7'h7F;
    drive      = running && (div_cnt >= BLANK_END) && frame_en[digit_idx] && pwm_on;
    if (drive) begin
      anodos_nxt[digit_idx] = 1'b0;
      seg_nxt               = frame_seg[digit_idx];
    end
  end

  // Registered pin drivers; dark whenever idle or starting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anodos <= '1;
      seg    <= 7'h7F;
    end else begin
      anodos <= anodos_nxt;
      seg    <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a time-based reference model predicts pin
// values per edge into a scoreboard queue; each task pops and compares.
module tb_seven_seg_scanner;

  localparam int ND = 4;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
  localparam int RD = 64;
`else
  localparam int RD = 8;
`endif
  localparam int BC = 2;
  localparam int FR = ND * RD;
  localparam int IW = $clog2(ND);

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    sg;
    logic [IW-1:0] idx;
    logic          tick;
  } out_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [7*ND-1:0]   seg_in;
  logic [ND-1:0]     digit_en;
  logic [ND-1:0]     anodos;
  logic [6:0]        seg;
  logic [IW-1:0]     digit_idx;
  logic              frame_tick;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
  logic [3:0]        brightness;
`endif

  int checks = 0;
  int passed = 0;

  // reference model state
  bit          m_run;
  int          m_k;
  logic [6:0]  m_seg [ND];
  logic [ND-1:0] m_en;
  int          m_bright;
  out_t        sb[$];
  out_t        got, exp_v;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .seg_in     (seg_in),
    .digit_en   (digit_en),
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .anodos     (anodos),
    .seg        (seg),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  task automatic snap();
    for (int i = 0; i < ND; i++) m_seg[i] = seg_in[7*i +: 7];
    m_en = digit_en;
  endtask

  // Predict the pins after the coming edge from the inputs now applied.
  // m_k counts edges since the start edge; pins after edge k show position
  // p = k-1 of the frame (one cycle of output latency).
  task automatic push_expect();
    out_t e;
    int p, d, sl;
    e = '{an: '1, sg: 7'h7F, idx: '0, tick: 1'b0};
    if (!enable) begin
      m_run = 0;
    end else if (!m_run) begin
      m_run = 1; m_k = 0; snap(); e.tick = 1'b1;
    end else begin
      m_k++;
      p = m_k - 1; d = p % RD; sl = (p / RD) % ND;
      if (d >= BC && m_en[sl] && (p % 16) < m_bright) begin
        e.an = ~(ND'(1) << sl);
        e.sg = m_seg[sl];
      end
      e.idx  = IW'((m_k / RD) % ND);
      e.tick = ((m_k % FR) == 0);
      if ((m_k % FR) == 0) snap();
    end
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (anodos !== '1) $display("FAIL reset_an got=%b exp=1111", anodos); else passed++;
    checks++; if (seg !== 7'h7F) $display("FAIL reset_seg got=%h exp=7f", seg); else passed++;
    checks++; if (digit_idx !== '0) $display("FAIL reset_idx got=%0d exp=0", digit_idx); else passed++;
    checks++; if (frame_tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", frame_tick); else passed++;
    rst_n = 1'b1;
    m_run = 0;
    @(posedge clk); #1;
    checks++; if ({anodos, seg} !== {{ND{1'b1}}, 7'h7F}) $display("FAIL idle_dark got=%b/%h exp=1111/7f", anodos, seg); else passed++;
  endtask

  task automatic test_scan();
    int ticks = 0;
    seg_in = {7'h40, 7'h79, 7'h24, 7'h30};
    digit_en = '1;
    enable = 1'b1;
    for (int c = 0; c <= 2 * FR; c++) begin
      push_expect();
      @(posedge clk); #1;
      got = {anodos, seg, digit_idx, frame_tick};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL scan k=%0d got(an,seg,idx,tick)=%b exp=%b", m_k, got, exp_v); else passed++;
      if (frame_tick) ticks++;
      if (c == 3) begin
        checks++;
        if ({anodos, seg} !== {4'b1110, 7'h30}) $display("FAIL scan_first_drive got=%b/%h exp=1110/30", anodos, seg); else passed++;
      end
    end
    checks++; if (ticks !== 3) $display("FAIL scan_tick_count got=%0d exp=3", ticks); else passed++;
  endtask

  task automatic test_snapshot();
    bit changed = 0;
    bit seen = 0;
    for (int c = 0; c < 2 * FR + 2; c++) begin
      if (!changed && m_run && (m_k % FR) == 2 * RD + 3) begin
        seg_in[6:0] = 7'h12;
        changed = 1;
      end
      push_expect();
      @(posedge clk); #1;
      got = {anodos, seg, digit_idx, frame_tick};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL snapshot k=%0d got(an,seg,idx,tick)=%b exp=%b", m_k, got, exp_v); else passed++;
      if (changed && !seen && anodos == 4'b1110) begin
        seen = 1;
        checks++;
        if (seg !== 7'h12) $display("FAIL snapshot_next_frame got=%h exp=12", seg); else passed++;
      end
    end
    checks++; if (!seen) $display("FAIL snapshot_seen got=0 exp=1"); else passed++;
  endtask

  task automatic test_mask();
    int bad = 0;
    for (int c = 0; c < FR && (m_k % FR) != FR - 1; c++) begin
      push_expect();
      @(posedge clk); #1;
      got = {anodos, seg, digit_idx, frame_tick};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL mask_align k=%0d got=%b exp=%b", m_k, got, exp_v); else passed++;
    end
    digit_en = 4'b1010;
    for (int c = 0; c < FR + 1; c++) begin
      push_expect();
      @(posedge clk); #1;
      got = {anodos, seg, digit_idx, frame_tick};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL mask k=%0d got(an,seg,idx,tick)=%b exp=%b", m_k, got, exp_v); else passed++;
      if (c >= 1 && (anodos[0] == 1'b0 || anodos[2] == 1'b0)) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL mask_masked_lit got=%0d exp=0", bad); else passed++;
    digit_en = '1;
  endtask

  task automatic test_enable_drop();
    for (int c = 0; c < 2 * FR && (m_k % FR) != RD + 4; c++) begin
      push_expect();
      @(posedge clk); #1;
      got = {anodos, seg, digit_idx, frame_tick};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL endrop_align k=%0d got=%b exp=%b", m_k, got, exp_v); else passed++;
    end
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      push_expect();
      @(posedge clk); #1;
      got = {anodos, seg, digit_idx, frame_tick};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL endrop_idle got=%b exp=%b", got, exp_v); else passed++;
      if (c == 0) begin
        checks++;
        if ({anodos, seg, digit_idx} !== {4'b1111, 7'h7F, 2'd0}) $display("FAIL endrop_dark got=%b/%h/%0d exp=1111/7f/0", anodos, seg, digit_idx); else passed++;
      end
    end
    enable = 1'b1;
    for (int c = 0; c < FR + 2; c++) begin
      push_expect();
      @(posedge clk); #1;
      got = {anodos, seg, digit_idx, frame_tick};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL endrop_restart k=%0d got=%b exp=%b", m_k, got, exp_v); else passed++;
      if (c == 0) begin
        checks++;
        if (frame_tick !== 1'b1) $display("FAIL endrop_tick got=%b exp=1", frame_tick); else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 2 * FR && (m_k % FR) != 2 * RD + 5; c++) begin
      push_expect();
      @(posedge clk); #1;
      got = {anodos, seg, digit_idx, frame_tick};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL areset_align k=%0d got=%b exp=%b", m_k, got, exp_v); else passed++;
    end
    checks++; if (anodos !== 4'b1011) $display("FAIL areset_pre_drive got=%b exp=1011", anodos); else passed++;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (anodos !== 4'b1111) $display("FAIL areset_an got=%b exp=1111", anodos); else passed++;
    checks++; if (seg !== 7'h7F) $display("FAIL areset_seg got=%h exp=7f", seg); else passed++;
    checks++; if (digit_idx !== '0) $display("FAIL areset_idx got=%0d exp=0", digit_idx); else passed++;
    m_run = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < FR + 2; c++) begin
      push_expect();
      @(posedge clk); #1;
      got = {anodos, seg, digit_idx, frame_tick};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL areset_restart k=%0d got=%b exp=%b", m_k, got, exp_v); else passed++;
    end
  endtask

`ifdef SEVEN_SEG_BRIGHTNESS_EN
  task automatic test_brightness();
    int low = 0;
    int lit = 0;
    brightness = 4'd4; m_bright = 4;
    for (int c = 0; c < FR + 1; c++) begin
      push_expect();
      @(posedge clk); #1;
      got = {anodos, seg, digit_idx, frame_tick};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL bright4 k=%0d got=%b exp=%b", m_k, got, exp_v); else passed++;
      if (((m_k - 1) % FR) >= 16 && ((m_k - 1) % FR) < 32 && anodos == 4'b1110) low++;
    end
    checks++; if (low !== 4) $display("FAIL bright4_duty got=%0d exp=4", low); else passed++;
    brightness = 4'd0; m_bright = 0;
    push_expect();
    @(posedge clk); #1;
    void'(sb.pop_front());
    for (int c = 0; c < FR; c++) begin
      push_expect();
      @(posedge clk); #1;
      got = {anodos, seg, digit_idx, frame_tick};
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL bright0 k=%0d got=%b exp=%b", m_k, got, exp_v); else passed++;
      if (anodos != 4'b1111) lit++;
    end
    checks++; if (lit !== 0) $display("FAIL bright0_dark got=%0d exp=0", lit); else passed++;
    brightness = 4'd15; m_bright = 15;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    seg_in = '1;
    digit_en = '0;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    brightness = 4'd15; m_bright = 15;
`else
    m_bright = 16;
`endif
    m_run = 0; m_k = 0; m_en = '0;
    for (int i = 0; i < ND; i++) m_seg[i] = 7'h7F;
    test_reset();
    test_scan();
    test_snapshot();
    test_mask();
    test_enable_drop();
    test_async_reset();
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    test_brightness();
`endif
    checks++; if (sb.size() !== 0) $display("FAIL sb_empty got=%0d exp=0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Parametrised multi-digit seven-segment display scanner with time-multiplexed outputs, active-low anodes and segments.
- Divides clk with its own refresh counter and walks NUM_DIGITS digit slots.
- Inserts an anti-ghosting blank interval at the start of each slot, masks digits per frame, and snapshots inputs once per frame so the display never tears.
- Sits between the display-encoding logic and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be ≥2.
- REFRESH_DIV, 50000: clk cycles per digit slot; must be ≥2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; low forces display dark and idle.
- seg_in  in  7*NUM_DIGITS  segment patterns, active-low. Digit i is bits [7i+6:7i].
- digit_en  in  NUM_DIGITS  per-digit enable mask. 0 blanks that digit.
- anodos  out  NUM_DIGITS  anode drives, active-low, at most one low at any time.
- seg  out  7  segment drive, active-low.
- digit_idx  out  clog2(NUM_DIGITS)  index of the current slot.
- frame_tick  out  1  one-cycle pulse when slot 0 begins.

Behaviour:
- Reset (asynchronous, rst_n low):
  - anodos all 1, seg 7'h7F, digit_idx 0, frame_tick 0.
  - div_cnt 0, frame registers cleared (all digits blank).
  - Internal start flag set.
  - Reset asserted mid-frame takes effect immediately, with no partial-slot completion.
- Idle state (enable=0): div_cnt, digit_idx and frame_tick held at 0; anodos all 1; seg 7'h7F; start flag set.
- Start:
  - Condition: first enabled cycle with the start flag set.
  - Action: capture seg_in and digit_en into the frame registers, clear the start flag, begin slot 0 with div_cnt=0.
  - frame_tick pulses on that edge.
- Counting:
  - div_cnt increments 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1, div_cnt wraps to 0 and digit_idx advances. digit_idx wraps from NUM_DIGITS-1 to 0.
- Frame wrap (digit_idx NUM_DIGITS-1→0):
  - Frame registers recapture seg_in/digit_en on the same edge.
  - frame_tick=1 for exactly that cycle.
  - Input changes at any other time are not visible until the next frame.
- Slot phases, derived from registered state; outputs are registered, 1 cycle latency behind div_cnt/digit_idx:
  - BLANK phase (div_cnt < BLANK_CYCLES): anodos all 1, seg 7'h7F.
  - DRIVE phase (div_cnt ≥ BLANK_CYCLES): seg = frame_seg[digit_idx].
    - If frame_en[digit_idx]=1, anodos bit digit_idx is 0 and all other bits are 1.
    - If frame_en[digit_idx]=0, anodos all 1 and seg 7'h7F.
- Frame period: NUM_DIGITS*REFRESH_DIV cycles. Each slot has REFRESH_DIV-BLANK_CYCLES drive cycles.
- enable falling mid-slot: on the next edge, outputs go dark and counters clear. Re-enable restarts at slot 0 with a fresh snapshot.
- Anode transitions always pass through an all-1 state of at least BLANK_CYCLES cycles when BLANK_CYCLES≥1.
- With BLANK_CYCLES=0, the blank phase is absent; anodos switches one-hot directly.

Optional Feature:
- Macro: SEVEN_SEG_BRIGHTNESS_EN.
- When defined:
  - Adds input port brightness (4 bits) and a free-running 4-bit PWM counter, cleared by reset and idle.
  - In the DRIVE phase, the selected anode is driven low only while pwm_cnt < brightness; otherwise all anodes are 1 and seg is 7'h7F.
  - brightness=0 gives a permanently dark display. brightness=15 gives 15/16 duty.
  - brightness is sampled every cycle; it is not frame-snapshotted.
- When undefined: no brightness port; DRIVE phase duty is 100%.

Test Plan:
- Common config for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset then enable=1, seg_in={7'h40,7'h79,7'h24,7'h30}, digit_en=4'hF:
  - frame_tick on the first enabled edge.
  - Per slot: anodos 1111 for 2 cycles, then 1110/1101/1011/0111 for 6 cycles each.
  - seg = 7'h30, 7'h24, 7'h79, 7'h40 in slots 0..3.
  - frame_tick repeats every 32 cycles.
- Change seg_in digit0 to 7'h12 during slot 2: slot 0 of the current frame is unaffected; 7'h12 appears in the next frame's slot 0.
- digit_en=4'b1010 at frame start: slots 0 and 2 keep anodos 1111 and seg 7'h7F; slots 1 and 3 drive normally.
- Drop enable for 3 cycles during slot 1 DRIVE:
  - Next edge gives anodos 1111, seg 7'h7F, digit_idx 0.
  - After re-enable, frame_tick pulses and slot 0 restarts.
- Assert rst_n=0 asynchronously mid-DRIVE: anodos 1111 and seg 7'h7F immediately, without a clock edge. Release restarts from slot 0.
- SEVEN_SEG_BRIGHTNESS_EN defined, brightness=4, REFRESH_DIV=64: in a DRIVE slot the anode is low for exactly 4 of every 16 pwm cycles. brightness=0 keeps anodos 1111 throughout.
